// File: rtl/retire_monitor_pkg.sv
// Shared types and default sizes for the retire monitor.
package retire_monitor_pkg;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ARCH_REGS    = 32;
  localparam int DEF_PHY_REGS     = 64;
  localparam int DEF_PHY_WIDTH    = 6;
  localparam int DEF_RETIRE_WIDTH = 2;
  localparam int DEF_CNT_WIDTH    = 32;

  localparam int DEF_ARCH_IDX_WIDTH = $clog2(DEF_ARCH_REGS);

  // Run-control phases of the monitor.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DUMP,
    HALT
  } monitor_state_t;

  // One architectural-register dump record at default sizes.
  typedef struct packed {
    logic [DEF_ARCH_IDX_WIDTH-1:0] idx;
    logic [DEF_DATA_WIDTH-1:0]     data;
  } dump_rec_t;

  // Which RAT feeds the dump: speculative after done, committed after timeout.
  typedef enum logic {
    SEL_FRONT,
    SEL_BACK
  } rat_sel_t;

endpackage

// File: rtl/retire_monitor_popcount_n.sv
// Combinational population count of an N-bit vector.
module popcount_n #(
  parameter int N = 2,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  // Sum the set bits.
  always_comb begin
    // NOTE: combinational blocks assign every output a default first and use
    // blocking '=', so no latch is inferred and later statements see earlier ones.
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/retire_monitor.sv
// Run-control and commit observer: counts cycles and retires, detects done or
// timeout, then streams every architectural register through one PRF port.
module retire_monitor
  import retire_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ARCH_REGS    = DEF_ARCH_REGS,
  parameter int PHY_REGS     = DEF_PHY_REGS,
  parameter int PHY_WIDTH    = DEF_PHY_WIDTH,
  parameter int RETIRE_WIDTH = DEF_RETIRE_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [CNT_WIDTH-1:0]               max_cycles,
  input  logic                               done_in,
  input  logic [RETIRE_WIDTH-1:0]            retire_valid,
  input  logic [RETIRE_WIDTH*ADDR_WIDTH-1:0] retire_addr,
  input  logic [ARCH_REGS*PHY_WIDTH-1:0]     front_rat,
  input  logic [ARCH_REGS*PHY_WIDTH-1:0]     back_rat,
  output logic [PHY_WIDTH-1:0]               prf_raddr,
  input  logic [DATA_WIDTH-1:0]              prf_rdata,
  output logic [CNT_WIDTH-1:0]               cycle_count,
  output logic [CNT_WIDTH-1:0]               retired_count,
  output logic [ADDR_WIDTH-1:0]              last_retire_addr,
  output logic                               dump_valid,
  output logic [$clog2(ARCH_REGS)-1:0]       dump_idx,
  output logic [DATA_WIDTH-1:0]              dump_data,
  output logic                               finished_ok,
  output logic                               timed_out,
  output logic                               halted
);

  localparam int IDX_WIDTH = $clog2(ARCH_REGS);
  localparam int POP_WIDTH = $clog2(RETIRE_WIDTH + 1);

  monitor_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0]    limit_q;
  logic [CNT_WIDTH-1:0]    cycle_q;
  logic [CNT_WIDTH-1:0]    retired_q;
  logic [ADDR_WIDTH-1:0]   last_addr_q;
  logic                    finished_q;
  logic                    timed_q;
  logic                    done_q;
  rat_sel_t                sel_q;
  // Extra MSB marks the drain cycle after the last issue (ARCH_REGS is a power of two).
  logic [IDX_WIDTH:0]      issue_idx_q;
  logic                    rec_valid_q;
  logic [IDX_WIDTH-1:0]    rec_idx_q;

  logic                    start_run;
  logic                    exit_done;
  logic                    exit_timeout;
  logic                    limit_hit;
  logic                    issuing;
  logic [POP_WIDTH-1:0]    retire_pop;
  logic [ADDR_WIDTH-1:0]   newest_addr;
  logic [IDX_WIDTH-1:0]    issue_idx;

  popcount_n #(
    .N (RETIRE_WIDTH),
    .W (POP_WIDTH)
  ) u_popcount (
    .bits  (retire_valid),
    .count (retire_pop)
  );

  // A limit of zero disables the timeout; otherwise this is the last RUN cycle.
  assign limit_hit = (limit_q != '0) && (cycle_q == limit_q - CNT_WIDTH'(1));
  assign issuing   = (state_q == DUMP) && !issue_idx_q[IDX_WIDTH];
  assign issue_idx = issue_idx_q[IDX_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and run-control strobes; done beats timeout in the same cycle.
  always_comb begin
    state_d      = state_q;
    start_run    = 1'b0;
    exit_done    = 1'b0;
    exit_timeout = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          start_run = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (done_q) begin
          exit_done = 1'b1;
          state_d   = DUMP;
        end else if (limit_hit) begin
          exit_timeout = 1'b1;
          state_d      = DUMP;
        end
      end
      DUMP: begin
        if (issue_idx_q[IDX_WIDTH]) begin
          state_d = HALT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PC of the highest-index valid retire port this cycle.
  always_comb begin
    newest_addr = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (retire_valid[k]) begin
        newest_addr = retire_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Counters, limit and sticky exit flags; frozen outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit_q     <= '0;
      cycle_q     <= '0;
      retired_q   <= '0;
      last_addr_q <= '0;
      finished_q  <= 1'b0;
      timed_q     <= 1'b0;
    end else if (start_run) begin
      limit_q     <= max_cycles;
      cycle_q     <= '0;
      retired_q   <= '0;
      last_addr_q <= '0;
      finished_q  <= 1'b0;
      timed_q     <= 1'b0;
    end else if (state_q == RUN) begin
      cycle_q   <= cycle_q + CNT_WIDTH'(1);
      retired_q <= retired_q + CNT_WIDTH'(retire_pop);
      if (|retire_valid) begin
        last_addr_q <= newest_addr;
      end
      if (exit_done) begin
        finished_q <= 1'b1;
      end
      if (exit_timeout) begin
        timed_q <= 1'b1;
      end
    end
  end

  // One-stage done register, only live during RUN so stale done cannot end a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == RUN) && done_in;
    end
  end

  // RAT selection latched at DUMP entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= SEL_FRONT;
    end else if (exit_done) begin
      sel_q <= SEL_FRONT;
    end else if (exit_timeout) begin
      sel_q <= SEL_BACK;
    end
  end

  // Issue index and the one-stage record pipeline matching the PRF read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_idx_q <= '0;
      rec_valid_q <= 1'b0;
      rec_idx_q   <= '0;
    end else begin
      rec_valid_q <= issuing;
      if (issuing) begin
        rec_idx_q   <= issue_idx;
        issue_idx_q <= issue_idx_q + 1'b1;
      end
      if (exit_done || exit_timeout) begin
        issue_idx_q <= '0;
      end
    end
  end

  // PRF read tag, sampled live from the selected RAT at the current index.
  always_comb begin
    prf_raddr = '0;
    if (issuing) begin
      if (sel_q == SEL_FRONT) begin
        prf_raddr = front_rat[issue_idx*PHY_WIDTH +: PHY_WIDTH];
      end else begin
        prf_raddr = back_rat[issue_idx*PHY_WIDTH +: PHY_WIDTH];
      end
    end
  end

  assign cycle_count      = cycle_q;
  assign retired_count    = retired_q;
  assign last_retire_addr = last_addr_q;
  assign finished_ok      = finished_q;
  assign timed_out        = timed_q;
  assign halted           = (state_q == HALT);
  assign dump_valid       = rec_valid_q;
  assign dump_idx         = rec_valid_q ? rec_idx_q : '0;
  assign dump_data        = rec_valid_q ? prf_rdata : '0;

endmodule

// File: tb/tb_retire_monitor.sv
// Self-checking bench for retire_monitor: directed runs from the test plan plus
// randomized runs checked against a run-level arithmetic model.
module tb_retire_monitor;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int PW = 6;
  localparam int RW = 2;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CW-1:0]    max_cycles;
  logic             done_in;
  logic [RW-1:0]    retire_valid;
  logic [RW*AW-1:0] retire_addr;
  logic [NR*PW-1:0] front_rat;
  logic [NR*PW-1:0] back_rat;
  logic [PW-1:0]    prf_raddr;
  logic [DW-1:0]    prf_rdata;
  logic [CW-1:0]    cycle_count;
  logic [CW-1:0]    retired_count;
  logic [AW-1:0]    last_retire_addr;
  logic             dump_valid;
  logic [4:0]       dump_idx;
  logic [DW-1:0]    dump_data;
  logic             finished_ok;
  logic             timed_out;
  logic             halted;

  // Narrow-counter instance for the wrap check.
  logic             start_w;
  logic [3:0]       max_w;
  logic             done_w;
  logic [PW-1:0]    prf_raddr_w;
  logic [DW-1:0]    prf_rdata_w;
  logic [3:0]       cycle_w;
  logic [3:0]       retired_w;
  logic [AW-1:0]    last_w;
  logic             dvalid_w;
  logic [4:0]       didx_w;
  logic [DW-1:0]    ddata_w;
  logic             fin_w;
  logic             to_w;
  logic             halted_w;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PW-1:0] front_tags [NR];
  logic [PW-1:0] back_tags  [NR];

  retire_monitor u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .max_cycles       (max_cycles),
    .done_in          (done_in),
    .retire_valid     (retire_valid),
    .retire_addr      (retire_addr),
    .front_rat        (front_rat),
    .back_rat         (back_rat),
    .prf_raddr        (prf_raddr),
    .prf_rdata        (prf_rdata),
    .cycle_count      (cycle_count),
    .retired_count    (retired_count),
    .last_retire_addr (last_retire_addr),
    .dump_valid       (dump_valid),
    .dump_idx         (dump_idx),
    .dump_data        (dump_data),
    .finished_ok      (finished_ok),
    .timed_out        (timed_out),
    .halted           (halted)
  );

  retire_monitor #(.CNT_WIDTH(4)) u_dut_w (
    .clk              (clk),
    .rst              (rst),
    .start            (start_w),
    .max_cycles       (max_w),
    .done_in          (done_w),
    .retire_valid     (retire_valid),
    .retire_addr      (retire_addr),
    .front_rat        (front_rat),
    .back_rat         (back_rat),
    .prf_raddr        (prf_raddr_w),
    .prf_rdata        (prf_rdata_w),
    .cycle_count      (cycle_w),
    .retired_count    (retired_w),
    .last_retire_addr (last_w),
    .dump_valid       (dvalid_w),
    .dump_idx         (didx_w),
    .dump_data        (ddata_w),
    .finished_ok      (fin_w),
    .timed_out        (to_w),
    .halted           (halted_w)
  );

  always #5 clk = ~clk;

  // PRF model: synchronous read, data = tag * 4.
  always @(posedge clk) begin
    prf_rdata   <= DW'(prf_raddr) << 2;
    prf_rdata_w <= DW'(prf_raddr_w) << 2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_rats(input bit seq);
    for (int i = 0; i < NR; i++) begin
      front_tags[i] = seq ? PW'(i + 32) : PW'($urandom);
      back_tags[i]  = PW'($urandom);
      front_rat[i*PW +: PW] = front_tags[i];
      back_rat[i*PW +: PW]  = back_tags[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"},  64'(cycle_count), 64'd0);
    check({tag, "_ret"},  64'(retired_count), 64'd0);
    check({tag, "_addr"}, 64'(last_retire_addr), 64'd0);
    check({tag, "_flags"}, {60'd0, dump_valid, finished_ok, timed_out, halted}, 64'd0);
    check({tag, "_didx"}, 64'(dump_idx), 64'd0);
    check({tag, "_ddata"}, 64'(dump_data), 64'd0);
    check({tag, "_raddr"}, 64'(prf_raddr), 64'd0);
  endtask

  // One complete run. lim = max_cycles, d = first RUN cycle with done_in high
  // (-1 = never), mode 1 = retire 2'b11 for the first 5 cycles only,
  // rst_at = record index at which reset is applied (-1 = none).
  task automatic do_run(input int lim, input int d, input int mode, input int rst_at);
    int            e;
    bit            by_done;
    logic [CW-1:0] exp_cyc;
    logic [CW-1:0] exp_ret;
    logic [AW-1:0] exp_addr;
    logic [RW-1:0] rv;
    logic [RW*AW-1:0] ra;
    logic [PW-1:0] tag;

    // Exit cycle: registered done seen one cycle after done_in, or limit-1.
    e = -1;
    if (d >= 0) e = d + 1;
    if (lim != 0 && (e < 0 || lim - 1 < e)) e = lim - 1;
    by_done = (d >= 0) && (d + 1 == e);

    start = 1'b1; max_cycles = CW'(lim); done_in = 1'b0;
    step();
    start = 1'b0;
    check("start_clr_cyc", 64'(cycle_count), 64'd0);
    check("start_clr_flags", {62'd0, finished_ok, timed_out}, 64'd0);

    exp_ret = '0; exp_addr = '0;
    for (int k = 0; k <= e; k++) begin
      rv = (mode == 1) ? ((k < 5) ? 2'b11 : 2'b00) : RW'($urandom);
      ra = {$urandom, $urandom};
      retire_valid = rv; retire_addr = ra;
      done_in = (d >= 0) && (k >= d);
      start = (k == 2);
      if (k == 2) max_cycles = CW'($urandom_range(1, 3));
      exp_ret = exp_ret + CW'($countones(rv));
      if (rv[1]) exp_addr = ra[2*AW-1:AW];
      else if (rv[0]) exp_addr = ra[AW-1:0];
      step();
      start = 1'b0;
    end
    exp_cyc = CW'(e + 1);

    check("exit_cyc", 64'(cycle_count), 64'(exp_cyc));
    check("exit_ret", 64'(retired_count), 64'(exp_ret));
    check("exit_addr", 64'(last_retire_addr), 64'(exp_addr));
    check("exit_fin", 64'(finished_ok), 64'(by_done));
    check("exit_to", 64'(timed_out), 64'(!by_done));
    check("exit_dv", 64'(dump_valid), 64'd0);

    // Dump phase: keep retiring and toggling done to show counters are frozen.
    retire_valid = RW'($urandom); done_in = 1'(($urandom));
    step();
    for (int i = 0; i < NR; i++) begin
      tag = by_done ? front_tags[i] : back_tags[i];
      check($sformatf("rec%0d_v", i), 64'(dump_valid), 64'd1);
      check($sformatf("rec%0d_idx", i), 64'(dump_idx), 64'(i));
      check($sformatf("rec%0d_data", i), 64'(dump_data), 64'(DW'(tag) * 4));
      check($sformatf("rec%0d_halt", i), 64'(halted), 64'd0);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
          retire_valid = 2'b11; done_in = 1'b1;
          step();
          check_all_zero($sformatf("post_rst%0d", j));
        end
        done_in = 1'b0;
        return;
      end
      if (i == 3) begin
        // Later RAT changes are still picked up for indices not yet read.
        front_tags[20] = PW'($urandom); back_tags[20] = PW'($urandom);
        front_rat[20*PW +: PW] = front_tags[20];
        back_rat[20*PW +: PW]  = back_tags[20];
      end
      retire_valid = RW'($urandom); done_in = 1'(($urandom));
      start = (i == 5);
      step();
      start = 1'b0;
    end
    check("halt_h", 64'(halted), 64'd1);
    check("halt_dv", 64'(dump_valid), 64'd0);
    check("halt_cyc", 64'(cycle_count), 64'(exp_cyc));
    check("halt_ret", 64'(retired_count), 64'(exp_ret));
    check("halt_flags", {62'd0, finished_ok, timed_out}, {62'd0, by_done, !by_done});
    done_in = 1'b0;
    retire_valid = '0;
  endtask

  initial begin
    int lim;
    int d;

    rst = 1'b1; start = 1'b0; max_cycles = '0; done_in = 1'b0;
    retire_valid = '0; retire_addr = '0;
    start_w = 1'b0; max_w = '0; done_w = 1'b0;
    load_rats(1'b1);
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Done-terminated run, front RAT holds i+32.
    do_run(0, 10, 1, -1);
    // Pure timeout at 20 cycles.
    load_rats(1'b0);
    do_run(20, -1, 0, -1);
    // Done and timeout in the same cycle.
    do_run(8, 6, 0, -1);
    // Timeout on the very first RUN cycle.
    do_run(1, -1, 0, -1);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      load_rats(1'b0);
      lim = int'($urandom_range(0, 40));
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 40));
      if (lim == 0 && d < 0) d = 5;
      do_run(lim, d, 0, -1);
    end

    // Reset in the middle of the dump, then a clean run from IDLE.
    do_run(0, 3, 0, 10);
    load_rats(1'b0);
    do_run(15, 30, 0, -1);

    // Narrow counters: 20 cycles of single-port retire wrap to 4.
    start_w = 1'b1; max_w = '0;
    step();
    start_w = 1'b0;
    for (int k = 0; k < 20; k++) begin
      retire_valid = 2'b01; retire_addr = {$urandom, $urandom};
      done_w = (k >= 18);
      step();
    end
    retire_valid = '0; done_w = 1'b0;
    check("wrap_cyc", 64'(cycle_w), 64'd4);
    check("wrap_ret", 64'(retired_w), 64'd4);
    check("wrap_fin", 64'(fin_w), 64'd1);
    for (int i = 0; i < NR + 1; i++) step();
    check("wrap_halt", 64'(halted_w), 64'd1);
    start_w = 1'b1; max_w = 4'd3;
    step();
    start_w = 1'b0;
    check("wrap_restart_cyc", 64'(cycle_w), 64'd0);
    check("wrap_restart_ret", 64'(retired_w), 64'd0);
    check("wrap_restart_flags", {61'd0, fin_w, to_w, halted_w}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_monitor.md
Name: retire_monitor

Overview:
- Synthesizable run-control and commit-observation block; replaces ad-hoc bench logic for cycle counting, done detection, timeout and architectural-register dump.
- Sits beside the CPU top and watches the RETIRE_WIDTH retire ports, the CPU done flag, both RATs and one PRF read port.
- Once the run ends (done or timeout), it walks every architectural register and streams its value out as one record per register.

Parameters:
ADDR_WIDTH, 32, retire address width
DATA_WIDTH, 32, register data width
ARCH_REGS, 32, architectural register count (power of two)
PHY_REGS, 64, physical register count
PHY_WIDTH, 6, physical tag width, clog2(PHY_REGS)
RETIRE_WIDTH, 2, retire ports observed per cycle
CNT_WIDTH, 32, cycle and retire counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; leaves IDLE, clears counters
max_cycles  in  CNT_WIDTH  timeout limit, sampled on start
done_in  in  1  CPU done flag, level
retire_valid  in  RETIRE_WIDTH  per-port retire valid
retire_addr  in  RETIRE_WIDTH*ADDR_WIDTH  per-port retire PC, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
front_rat  in  ARCH_REGS*PHY_WIDTH  speculative RAT, flat
back_rat  in  ARCH_REGS*PHY_WIDTH  committed RAT, flat
prf_raddr  out  PHY_WIDTH  PRF read tag
prf_rdata  in  DATA_WIDTH  PRF data, valid one cycle after prf_raddr
cycle_count  out  CNT_WIDTH  cycles spent in RUN
retired_count  out  CNT_WIDTH  total retired instructions
last_retire_addr  out  ADDR_WIDTH  PC of the highest-index valid port in the last retiring cycle
dump_valid  out  1  dump record valid
dump_idx  out  clog2(ARCH_REGS)  architectural register index
dump_data  out  DATA_WIDTH  architectural register value
finished_ok  out  1  sticky; run ended by done
timed_out  out  1  sticky; run ended by timeout
halted  out  1  high in HALT

Behaviour:
- Reset: all outputs 0, state IDLE, limit register 0, dump index 0.
- States: IDLE, RUN, DUMP, HALT.
- IDLE:
  - On start: clear cycle_count, retired_count, last_retire_addr, finished_ok and timed_out; latch max_cycles; go to RUN next cycle.
  - Retire and done_in are ignored in IDLE.
- RUN, counters:
  - cycle_count increments by 1 every cycle.
  - retired_count increments by the popcount of retire_valid, 0..RETIRE_WIDTH, in the same cycle.
  - last_retire_addr updates only when some retire_valid bit is set.
  - Counters wrap modulo 2^CNT_WIDTH and never saturate.
- RUN, exit conditions:
  - done_in is registered one stage. When the registered done is high: set finished_ok, select front_rat, go to DUMP.
  - Else if cycle_count equals the latched limit minus 1 (limit reached this cycle): set timed_out, select back_rat, go to DUMP.
  - Done has priority if both occur in the same cycle.
  - Latched limit 0: never time out.
  - Retires present in the exit cycle are still counted.
- DUMP:
  - Each cycle, drive prf_raddr = selected_rat[i].
  - One cycle later: dump_valid=1, dump_idx=i, dump_data=prf_rdata. The read pipeline is one stage.
  - i runs 0..ARCH_REGS-1, one issue per cycle.
  - Exactly ARCH_REGS records, on consecutive cycles.
  - The first record appears 2 cycles after the exit cycle; the last record is followed by the transition to HALT.
  - Counters are frozen in DUMP.
- HALT: halted=1 and dump_valid=0 until start, which behaves as in IDLE (new run).
- start outside IDLE and HALT is ignored.
- Reset mid-run or mid-dump: immediate return to reset values; no partial record is emitted after rst deasserts.
- The RAT selection is latched at DUMP entry; later changes to front_rat or back_rat tags are still sampled live per index.

Decomposition:
- Add to parameter_pkg: RETIRE_WIDTH, CNT_WIDTH.
- Add to typedef_pkg: monitor_state_t enum {IDLE, RUN, DUMP, HALT}; dump_rec_t struct {idx, data}.
- Sub-module popcount_n, parameter N, combinational popcount of retire_valid.

Test Plan:
- Reset, start with max_cycles=0, retire_valid=2'b11 for 5 cycles, then done_in at cycle 10 -> retired_count=10, finished_ok=1, 32 dump records from front_rat, halted=1.
- max_cycles=20, done_in never asserted -> exit when cycle_count=20, timed_out=1, dump uses back_rat, idx 0..31 consecutive.
- Done and timeout in the same cycle (max_cycles=8, registered done at cycle 7) -> finished_ok=1, timed_out=0.
- PRF model returning data=tag*4, front_rat[i]=i+32 -> dump_data for record i = 4*(i+32).
- rst asserted mid-DUMP at record 10 -> all outputs 0 next cycle, no further dump_valid, state IDLE.
- CNT_WIDTH=4, 20 cycles of single-port retire -> retired_count wraps to 4; then start from HALT -> counters cleared.
